cpu_ctrl_fsm: RTL and testbench
===============================

# cpu_ctrl_fsm

Multi-cycle control sequencer for the 32-bit, 6-bit-register-field CPU datapath. Steps each instruction through FETCH, DECODE, EXEC, MEM and WB and drives every datapath strobe: PC/IR/register-file write enables, ALU op, the zero-extended {rs,rt} immediate select and the memory request/acknowledge handshake. It also holds the architectural Z/N flags. It sits beside the datapath and takes only the opcode field, the ALU flags and the memory acknowledge.

## Interface
- MAX_WAIT, 15: cycles `mem_req` may stay high without `mem_ack` before a fault; legal range 1–255.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- opcode  in  4  IR[31:28]; valid from DECODE onward.
- alu_z, alu_n  in  1  zero/negative of the current ALU result; valid in EXEC.
- mem_ack  in  1  memory accepted or returned data this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  store when high, read when low; qualified by `mem_req`.
- mem_addr_sel  out  1  memory address source: 0 = PC, 1 = rs.
- ir_we  out  1  load the instruction register.
- pc_we  out  1  write the PC.
- pc_src  out  2  PC source: 0 = PC+1, 1 = rs, 2 = memory data.
- reg_we  out  1  register-file write.
- wb_sel  out  2  write-back source: 0 = ALU, 1 = memory data, 2 = PC + immediate.
- alu_op  out  3  0 = PASS_A, 1 = ADD, 2 = SUB, 3 = NEG.
- imm_sel  out  1  ALU operand B = zero-extended 12-bit {rs,rt} immediate.
- flag_z, flag_n  out  1  registered architectural flags.
- state  out  3  current state encoding, for debug.
- err  out  1  sticky fault indicator.

## Operation
- Opcodes: NOP 0000, ST 0011, ADD 0100, INC 0101, NEG 0110, SUB 0111, J 1000, BRZ 1001, JM 1010, BRN 1011, LD 1110, SVPC 1111. Opcodes 0001, 0010, 1100 and 1101 are illegal.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH
  - Drives `mem_req`=1, `mem_addr_sel`=0.
  - On `mem_ack`: `ir_we`=1, `pc_we`=1, `pc_src`=0, next state DECODE.
- DECODE: no strobes; one cycle for register-file read.
  - NOP goes to FETCH.
  - Illegal opcode goes to HALT and sets `err`.
  - All other opcodes go to EXEC.
- EXEC
  - ADD and SUB: `alu_op` = ADD or SUB respectively.
  - NEG: `alu_op` = NEG.
  - INC: `alu_op` = ADD with `imm_sel`=1.
  - SVPC: `imm_sel`=1.
  - ADD, SUB, NEG and INC load `flag_z`/`flag_n` from `alu_z`/`alu_n` at the end of EXEC, then go to WB. No other instruction touches the flags.
  - J: `pc_we`=1, `pc_src`=1, then FETCH.
  - BRZ when `flag_z`=1, or BRN when `flag_n`=1: `pc_we`=1, `pc_src`=1, then FETCH. When the flag is clear: no PC write, then FETCH.
  - LD, ST and JM go to MEM.
- MEM
  - Drives `mem_req`=1, `mem_addr_sel`=1, and `mem_we`=1 for ST only.
  - On `mem_ack`:
    - LD goes to WB.
    - ST goes to FETCH.
    - JM asserts `pc_we`=1 with `pc_src`=2, then goes to FETCH.
- WB: `reg_we`=1 for one cycle, then FETCH.
  - `wb_sel` = 1 for LD.
  - `wb_sel` = 2 for SVPC: rd = incremented PC + zero-extended {rs,rt}.
  - `wb_sel` = 0 otherwise.
- Timeout
  - A wait counter runs while `mem_req`=1 and `mem_ack`=0. It clears on ack and on every state change.
  - When the count reaches MAX_WAIT, the FSM goes to HALT and sets `err`.
- HALT
  - All strobes are 0; `state` reads HALT.
  - Only `rst` exits HALT.
  - `err` is sticky until reset.

## Timing
- All strobes are combinational from state, `opcode`, `mem_ack` and the flags. `flag_z`, `flag_n`, `err`, `state` and the wait counter are registered.
- `mem_ack` in the same cycle as `mem_req` completes the access at that rising edge.
- Latency with zero-wait memory:
  - ALU instructions and SVPC: 4 cycles.
  - LD: 5 cycles.
  - ST and JM: 4 cycles.
  - J, BRZ and BRN: 3 cycles.
  - NOP: 2 cycles.
- Each memory wait cycle adds 1 cycle.
- Reset, including mid-access:
  - State becomes FETCH.
  - `flag_z`, `flag_n`, `err` and the counter become 0.
  - While `rst` is high, every strobe is forced to 0, including `mem_req`, so an in-flight request is dropped.
  - The first `mem_req` appears in the first cycle after `rst` falls.
- `mem_ack` outside FETCH or MEM is ignored.

## Structure
- Package `cpu_pkg` holds:
  - opcode localparams;
  - the state encoding (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5);
  - the `alu_op`, `pc_src` and `wb_sel` encodings.
- One sub-module, `mem_wait_timer`: an 8-bit counter with `clear`, `count_en` and `expired` (count == MAX_WAIT).

## Test plan
- **Reset, then ADD.** Release `rst`, hold `mem_ack`=1, opcode ADD, `alu_z`=1 in EXEC → `ir_we` and `pc_we` on cycle 0, `reg_we` on cycle 3, `flag_z`=1, next FETCH on cycle 4.
- **LD with wait states.** LD with `mem_ack` delayed 3 cycles in MEM → `mem_req`=1, `mem_addr_sel`=1, `mem_we`=0 for 4 cycles, then WB with `wb_sel`=1, 8 cycles total.
- **Branches against flags.** BRZ with `flag_z`=0 → no `pc_we` in EXEC. BRN with `flag_n`=1 → `pc_we`=1, `pc_src`=1.
- **Timeout.** MAX_WAIT=4 and `mem_ack` never asserted in FETCH → HALT after 4 cycles, `err`=1, all strobes 0 until `rst`.
- **Illegal opcode.** Opcode 1100 → HALT directly from DECODE, `err`=1.
- **Reset mid-store.** Assert `rst` during ST in MEM → `mem_req` and `mem_we` drop to 0 in the same cycle, flags cleared, restart in FETCH.

Source files
------------

// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle CPU control sequencer: opcodes,
// sequencer states and the datapath mux/ALU select codes.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_NEG  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_BRZ  = 4'b1001;
  localparam logic [3:0] OP_JM   = 4'b1010;
  localparam logic [3:0] OP_BRN  = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_SVPC = 4'b1111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] ALU_PASS_A = 3'd0;
  localparam logic [2:0] ALU_ADD    = 3'd1;
  localparam logic [2:0] ALU_SUB    = 3'd2;
  localparam logic [2:0] ALU_NEG    = 3'd3;

  localparam logic [1:0] PC_SRC_INC = 2'd0;
  localparam logic [1:0] PC_SRC_RS  = 2'd1;
  localparam logic [1:0] PC_SRC_MEM = 2'd2;

  localparam logic [1:0] WB_SEL_ALU    = 2'd0;
  localparam logic [1:0] WB_SEL_MEM    = 2'd1;
  localparam logic [1:0] WB_SEL_PC_IMM = 2'd2;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == 4'b0001) || (op == 4'b0010) || (op == 4'b1100) || (op == 4'b1101);
  endfunction

  // Instructions that produce an ALU result and therefore update Z/N.
  function automatic logic is_alu_instr(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_INC) || (op == OP_NEG) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_mem_wait_timer.sv
// Memory wait-state counter: counts stalled request cycles and flags the
// cycle in which the stall count would reach MAX_WAIT.
module mem_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [7:0] count_q;
  logic [7:0] count_d;
  logic [7:0] count_inc;

  assign count_inc = count_q + 8'd1;

  // Looks one edge ahead so the sequencer leaves on the very edge at which
  // the count hits MAX_WAIT; it never depends on clear, avoiding a loop
  // through the sequencer's state-change detection.
  assign expired = count_en && (count_inc == MAX_WAIT_C);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en) begin
      count_d = count_inc;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer: steps FETCH/DECODE/EXEC/MEM/WB, drives all
// datapath strobes, holds the architectural Z/N flags and a sticky fault.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic [2:0] alu_op,
  output logic       imm_sel,
  output logic       flag_z,
  output logic       flag_n,
  output logic [2:0] state,
  output logic       err
);

  state_t state_q, state_d;
  logic   flag_z_q, flag_z_d;
  logic   flag_n_q, flag_n_d;
  logic   err_q, err_d;

  logic       mem_req_c, mem_we_c, mem_addr_sel_c, ir_we_c, pc_we_c;
  logic       reg_we_c, imm_sel_c;
  logic [1:0] pc_src_c, wb_sel_c;
  logic [2:0] alu_op_c;

  logic wait_expired;
  logic wait_clear;
  logic wait_count_en;

  assign wait_count_en = mem_req_c && !mem_ack;
  assign wait_clear    = mem_ack || (state_d != state_q);

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_mem_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (wait_clear),
    .count_en (wait_count_en),
    .expired  (wait_expired)
  );

  // NOTE: every combinational output gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    flag_z_d       = flag_z_q;
    flag_n_d       = flag_n_q;
    err_d          = err_q;
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_addr_sel_c = 1'b0;
    ir_we_c        = 1'b0;
    pc_we_c        = 1'b0;
    pc_src_c       = PC_SRC_INC;
    reg_we_c       = 1'b0;
    wb_sel_c       = WB_SEL_ALU;
    alu_op_c       = ALU_PASS_A;
    imm_sel_c      = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ack) begin
          ir_we_c  = 1'b1;
          pc_we_c  = 1'b1;
          pc_src_c = PC_SRC_INC;
          state_d  = ST_DECODE;
        end else if (wait_expired) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end
      end

      ST_DECODE: begin
        if (opcode == OP_NOP) begin
          state_d = ST_FETCH;
        end else if (is_illegal(opcode)) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        case (opcode)
          OP_ADD:  alu_op_c = ALU_ADD;
          OP_SUB:  alu_op_c = ALU_SUB;
          OP_NEG:  alu_op_c = ALU_NEG;
          OP_INC: begin
            alu_op_c  = ALU_ADD;
            imm_sel_c = 1'b1;
          end
          OP_SVPC: imm_sel_c = 1'b1;
          OP_J: begin
            pc_we_c  = 1'b1;
            pc_src_c = PC_SRC_RS;
          end
          OP_BRZ: begin
            pc_we_c  = flag_z_q;
            pc_src_c = flag_z_q ? PC_SRC_RS : PC_SRC_INC;
          end
          OP_BRN: begin
            pc_we_c  = flag_n_q;
            pc_src_c = flag_n_q ? PC_SRC_RS : PC_SRC_INC;
          end
          default: ;
        endcase

        if (is_alu_instr(opcode) || opcode == OP_SVPC) begin
          state_d = ST_WB;
        end else if (opcode == OP_LD || opcode == OP_ST || opcode == OP_JM) begin
          state_d = ST_MEM;
        end

        if (is_alu_instr(opcode)) begin
          flag_z_d = alu_z;
          flag_n_d = alu_n;
        end
      end

      ST_MEM: begin
        mem_req_c      = 1'b1;
        mem_addr_sel_c = 1'b1;
        mem_we_c       = (opcode == OP_ST);
        if (mem_ack) begin
          state_d = (opcode == OP_LD) ? ST_WB : ST_FETCH;
          if (opcode == OP_JM) begin
            pc_we_c  = 1'b1;
            pc_src_c = PC_SRC_MEM;
          end
        end else if (wait_expired) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end
      end

      ST_WB: begin
        reg_we_c = 1'b1;
        state_d  = ST_FETCH;
        if (opcode == OP_LD) begin
          wb_sel_c = WB_SEL_MEM;
        end else if (opcode == OP_SVPC) begin
          wb_sel_c = WB_SEL_PC_IMM;
        end
      end

      ST_HALT: ;

      default: begin
        state_d = ST_HALT;
        err_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
      err_q    <= err_d;
    end
  end

  // Reset squashes the strobes combinationally so an in-flight memory
  // request is dropped in the same cycle reset rises.
  always_comb begin
    mem_req      = mem_req_c      && !rst;
    mem_we       = mem_we_c       && !rst;
    mem_addr_sel = mem_addr_sel_c && !rst;
    ir_we        = ir_we_c        && !rst;
    pc_we        = pc_we_c        && !rst;
    reg_we       = reg_we_c       && !rst;
    imm_sel      = imm_sel_c      && !rst;
    pc_src       = rst ? 2'd0 : pc_src_c;
    wb_sel       = rst ? 2'd0 : wb_sel_c;
    alu_op       = rst ? 3'd0 : alu_op_c;
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
  assign err    = err_q;
  assign state  = state_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: the driver pushes a hand-written
// expected output vector per cycle, a monitor pops and compares at negedge.
module tb_cpu_ctrl_fsm;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       alu_z, alu_n, mem_ack;
  logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we, imm_sel;
  logic [1:0] pc_src, wb_sel;
  logic [2:0] alu_op, state;
  logic       flag_z, flag_n, err;

  always #5 clk = ~clk;

  cpu_ctrl_fsm #(.MAX_WAIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .alu_z        (alu_z),
    .alu_n        (alu_n),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .alu_op       (alu_op),
    .imm_sel      (imm_sel),
    .flag_z       (flag_z),
    .flag_n       (flag_n),
    .state        (state),
    .err          (err)
  );

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic [2:0] alu_op;
    logic       imm_sel;
    logic       flag_z;
    logic       flag_n;
    logic [2:0] state;
    logic       err;
  } obs_t;

  obs_t  act;
  obs_t  q_exp[$];
  string q_name[$];
  int    n_checks = 0;
  int    n_errors = 0;

  // Expected architectural state, updated by hand at the point it changes.
  logic ez = 1'b0, en = 1'b0, ee = 1'b0;

  always_comb act = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_we,
                     wb_sel, alu_op, imm_sel, flag_z, flag_n, state, err};

  function automatic obs_t mk(input logic [2:0] st, input logic req, input logic we,
                              input logic asel, input logic irwe, input logic pcwe,
                              input logic [1:0] pcs, input logic regwe,
                              input logic [1:0] wbs, input logic [2:0] aop,
                              input logic imm);
    return {req, we, asel, irwe, pcwe, pcs, regwe, wbs, aop, imm, ez, en, st, ee};
  endfunction

  task automatic check(input string nm, input obs_t got, input obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%05h (state %0d err %b) required=%05h (state %0d err %b)",
               nm, got, got.state, got.err, exp, exp.state, exp.err);
    end
  endtask

  initial begin
    obs_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        e  = q_exp.pop_front();
        nm = q_name.pop_front();
        check(nm, act, e);
      end
    end
  end

  task automatic cyc(input logic r, input logic [3:0] op, input logic ack,
                     input logic z, input logic n, input obs_t e, input string nm);
    rst     = r;
    opcode  = op;
    mem_ack = ack;
    alu_z   = z;
    alu_n   = n;
    q_exp.push_back(e);
    q_name.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Stray ack and flag inputs are held high where they must be ignored.
  task automatic fetch_decode(input logic [3:0] op, input string nm);
    cyc(1'b0, op, 1'b1, 1'b1, 1'b1, mk(ST_FETCH, 1, 0, 0, 1, 1, 2'd0, 0, 2'd0, 3'd0, 0),
        {nm, "_fetch"});
    cyc(1'b0, op, 1'b1, 1'b1, 1'b1, mk(ST_DECODE, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 3'd0, 0),
        {nm, "_decode"});
  endtask

  task automatic alu_instr(input logic [3:0] op, input logic [2:0] aop, input logic imm,
                           input logic z, input logic n, input logic [1:0] wbs,
                           input logic loads_flags, input string nm);
    fetch_decode(op, nm);
    cyc(1'b0, op, 1'b1, z, n, mk(ST_EXEC, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, aop, imm),
        {nm, "_exec"});
    if (loads_flags) begin
      ez = z;
      en = n;
    end
    cyc(1'b0, op, 1'b1, 1'b1, 1'b1, mk(ST_WB, 0, 0, 0, 0, 0, 2'd0, 1, wbs, 3'd0, 0),
        {nm, "_wb"});
  endtask

  task automatic branch_instr(input logic [3:0] op, input logic taken, input string nm);
    fetch_decode(op, nm);
    cyc(1'b0, op, 1'b1, 1'b1, 1'b1,
        mk(ST_EXEC, 0, 0, 0, 0, taken, taken ? 2'd1 : 2'd0, 0, 2'd0, 3'd0, 0),
        {nm, "_exec"});
  endtask

  task automatic mem_instr(input logic [3:0] op, input int waits, input string nm);
    logic we;
    logic jm;
    we = (op == OP_ST);
    jm = (op == OP_JM);
    fetch_decode(op, nm);
    cyc(1'b0, op, 1'b1, 1'b1, 1'b1, mk(ST_EXEC, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 3'd0, 0),
        {nm, "_exec"});
    for (int i = 0; i < waits; i++)
      cyc(1'b0, op, 1'b0, 1'b1, 1'b1, mk(ST_MEM, 1, we, 1, 0, 0, 2'd0, 0, 2'd0, 3'd0, 0),
          {nm, "_mem_wait"});
    cyc(1'b0, op, 1'b1, 1'b1, 1'b1,
        mk(ST_MEM, 1, we, 1, 0, jm, jm ? 2'd2 : 2'd0, 0, 2'd0, 3'd0, 0), {nm, "_mem_ack"});
    if (op == OP_LD)
      cyc(1'b0, op, 1'b1, 1'b1, 1'b1, mk(ST_WB, 0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 3'd0, 0),
          {nm, "_wb"});
  endtask

  task automatic reset_cycle(input string nm);
    ez = 1'b0;
    en = 1'b0;
    ee = 1'b0;
    cyc(1'b1, OP_ADD, 1'b1, 1'b1, 1'b1, mk(ST_FETCH, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 3'd0, 0),
        nm);
  endtask

  task automatic halt_cycles(input int cnt, input logic [3:0] op, input string nm);
    for (int i = 0; i < cnt; i++)
      cyc(1'b0, op, 1'b1, 1'b1, 1'b1, mk(ST_HALT, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 3'd0, 0), nm);
  endtask

  initial begin
    rst = 1'b1; opcode = OP_NOP; mem_ack = 1'b1; alu_z = 1'b1; alu_n = 1'b1;
    @(posedge clk);
    #1;
    reset_cycle("reset_hold");
    reset_cycle("reset_hold");

    // Zero-wait sequence exercising every instruction class.
    alu_instr(OP_ADD, ALU_ADD, 1'b0, 1'b1, 1'b0, WB_SEL_ALU, 1'b1, "add");
    mem_instr(OP_LD, 3, "ld");
    branch_instr(OP_BRZ, 1'b1, "brz_taken");
    alu_instr(OP_INC, ALU_ADD, 1'b1, 1'b0, 1'b0, WB_SEL_ALU, 1'b1, "inc");
    branch_instr(OP_BRZ, 1'b0, "brz_not_taken");
    alu_instr(OP_NEG, ALU_NEG, 1'b0, 1'b0, 1'b1, WB_SEL_ALU, 1'b1, "neg");
    branch_instr(OP_BRN, 1'b1, "brn_taken");
    alu_instr(OP_SVPC, ALU_PASS_A, 1'b1, 1'b1, 1'b0, WB_SEL_PC_IMM, 1'b0, "svpc");
    mem_instr(OP_JM, 0, "jm");
    fetch_decode(OP_NOP, "nop");
    branch_instr(OP_J, 1'b1, "j");
    mem_instr(OP_ST, 1, "st");
    alu_instr(OP_SUB, ALU_SUB, 1'b0, 1'b1, 1'b1, WB_SEL_ALU, 1'b1, "sub");
    branch_instr(OP_BRN, 1'b1, "brn_after_sub");

    // Reset while a store is stalled in MEM.
    fetch_decode(OP_ST, "st_rst");
    cyc(1'b0, OP_ST, 1'b1, 1'b1, 1'b1, mk(ST_EXEC, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 3'd0, 0),
        "st_rst_exec");
    cyc(1'b0, OP_ST, 1'b0, 1'b1, 1'b1, mk(ST_MEM, 1, 1, 1, 0, 0, 2'd0, 0, 2'd0, 3'd0, 0),
        "st_rst_mem_wait");
    reset_cycle("st_rst_drop");
    reset_cycle("st_rst_hold");

    // Fetch never acknowledged: four request cycles, then HALT.
    for (int i = 0; i < 4; i++)
      cyc(1'b0, OP_ADD, 1'b0, 1'b1, 1'b1, mk(ST_FETCH, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 3'd0, 0),
          "timeout_fetch_wait");
    ee = 1'b1;
    halt_cycles(3, OP_ADD, "timeout_halt");
    reset_cycle("timeout_reset");

    // Illegal opcode halts straight from DECODE.
    fetch_decode(4'b1100, "illegal");
    ee = 1'b1;
    halt_cycles(2, 4'b1100, "illegal_halt");
    reset_cycle("illegal_reset");
    cyc(1'b0, OP_NOP, 1'b0, 1'b1, 1'b1, mk(ST_FETCH, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 3'd0, 0),
        "restart_fetch");

    repeat (2) @(negedge clk);
    n_checks++;
    if (q_exp.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: actual=%0d pending required=0", q_exp.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
